// File: rtl/ecc_pkg.sv
// Shared state encoding and scalar-width default for the ECC scalar-multiplication sequencer.
package ecc_pkg;

    localparam int KEY_BITS_DEF = 32;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_EVAL     = 4'd1,
        ST_DBL      = 4'd2,
        ST_WAIT_DBL = 4'd3,
        ST_ADD      = 4'd4,
        ST_WAIT_ADD = 4'd5,
        ST_NEXT     = 4'd6,
        ST_WAIT_KEY = 4'd7,
        ST_FIN      = 4'd8
    } state_t;

endpackage

// File: rtl/ecc_scalar_ctrl.sv
// Left-to-right double-and-add sequencer computing Q = k*P over an MSB-first key bit stream.
// Optional busy-cycle counter output o_cycles when ECC_SCALAR_CYCLE_CNT_EN is defined.
module ecc_scalar_ctrl
    import ecc_pkg::*;
#(
    parameter int KEY_BITS = KEY_BITS_DEF,
    parameter int CNT_W    = 6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_key_bit,
    output logic        o_key_next,
    input  logic        i_key_ack,
    output logic        o_load_p,
    output logic        o_dbl_start,
    input  logic        i_dbl_done,
    output logic        o_add_start,
    input  logic        i_add_done,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_inf
`ifdef ECC_SCALAR_CYCLE_CNT_EN
    ,
    output logic [31:0] o_cycles
`endif
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             inf, inf_nxt;
    logic             bit_r, bit_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            inf   <= 1'b1;
            bit_r <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            inf   <= inf_nxt;
            bit_r <= bit_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        inf_nxt     = inf;
        bit_nxt     = bit_r;
        o_key_next  = 1'b0;
        o_load_p    = 1'b0;
        o_dbl_start = 1'b0;
        o_add_start = 1'b0;
        o_done      = 1'b0;
        o_busy      = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_EVAL;
                    cnt_nxt   = CNT_W'(KEY_BITS - 1);
                    inf_nxt   = 1'b1;
                end
            end
            ST_EVAL: begin
                bit_nxt = i_key_bit;
                // While R is at infinity the first set bit is a plain load of P.
                if (inf) begin
                    if (i_key_bit) begin
                        o_load_p = 1'b1;
                        inf_nxt  = 1'b0;
                    end
                    state_nxt = ST_NEXT;
                end else begin
                    state_nxt = ST_DBL;
                end
            end
            ST_DBL: begin
                o_dbl_start = 1'b1;
                state_nxt   = ST_WAIT_DBL;
            end
            ST_WAIT_DBL: begin
                if (i_dbl_done) begin
                    state_nxt = bit_r ? ST_ADD : ST_NEXT;
                end
            end
            ST_ADD: begin
                o_add_start = 1'b1;
                state_nxt   = ST_WAIT_ADD;
            end
            ST_WAIT_ADD: begin
                if (i_add_done) begin
                    state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // The MSB is presented at start, so only KEY_BITS-1 advances are requested.
                if (cnt == '0) begin
                    state_nxt = ST_FIN;
                end else begin
                    o_key_next = 1'b1;
                    cnt_nxt    = cnt - CNT_W'(1);
                    state_nxt  = ST_WAIT_KEY;
                end
            end
            ST_WAIT_KEY: begin
                if (i_key_ack) begin
                    state_nxt = ST_EVAL;
                end
            end
            ST_FIN: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_inf = inf;

`ifdef ECC_SCALAR_CYCLE_CNT_EN
    // The FIN cycle is not counted so the value seen with o_done stays put afterwards.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cycles <= '0;
        end else if ((state == ST_IDLE) && i_start) begin
            o_cycles <= '0;
        end else if (o_busy && !o_done && (o_cycles != 32'hFFFF_FFFF)) begin
            o_cycles <= o_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ecc_scalar_ctrl.sv
// Directed self-checking bench for ecc_scalar_ctrl: drives a key shifter and point-unit model,
// counts issued commands per run and compares them with hand-computed values.
module tb_ecc_scalar_ctrl;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_start = 1'b0;
    logic i_key_bit = 1'b0;
    logic i_key_ack = 1'b0;
    logic i_dbl_done = 1'b0;
    logic i_add_done = 1'b0;
    logic o_key_next, o_load_p, o_dbl_start, o_add_start, o_busy, o_done, o_inf;

    int n_tests = 0;
    int n_fail  = 0;

    int n_next, n_load, n_dbl, n_add, n_multi, n_order, busy_bad;
    bit got_done, inf_done;

    ecc_scalar_ctrl dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_key_bit   (i_key_bit),
        .o_key_next  (o_key_next),
        .i_key_ack   (i_key_ack),
        .o_load_p    (o_load_p),
        .o_dbl_start (o_dbl_start),
        .i_dbl_done  (i_dbl_done),
        .o_add_start (o_add_start),
        .i_add_done  (i_add_done),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_inf       (o_inf)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [6:0] out_vec();
        return {o_load_p, o_dbl_start, o_add_start, o_key_next, o_busy, o_done, o_inf};
    endfunction

    // mode 0: plain run; mode 1: stray i_start + i_add_done in first WAIT_DBL; mode 2: reset in WAIT_DBL.
    task automatic run_key(input logic [31:0] key, input int lat, input int mode, input string tag);
        int  idx      = 31;
        bit  ack_due  = 1'b0;
        int  dbl_cd   = 0;
        int  add_cd   = 0;
        bit  last_dbl = 1'b0;
        bit  prev_dbl = 1'b0;
        bit  disturbed = 1'b0;
        n_next = 0; n_load = 0; n_dbl = 0; n_add = 0;
        n_multi = 0; n_order = 0; busy_bad = 0;
        got_done = 1'b0; inf_done = 1'b0;

        @(negedge i_clk);
        i_start   = 1'b1;
        i_key_bit = key[31];
        #1;
        check({tag, "_idle_busy"}, o_busy, 1'b0);

        for (int c = 0; c < 2000 && !got_done; c++) begin
            @(negedge i_clk);
            i_start    = 1'b0;
            i_key_ack  = ack_due;
            ack_due    = 1'b0;
            i_dbl_done = (dbl_cd == 1);
            i_add_done = (add_cd == 1);
            if (dbl_cd > 0) dbl_cd--;
            if (add_cd > 0) add_cd--;
            i_key_bit  = (idx >= 0) ? key[idx] : 1'b0;
            if (prev_dbl && mode == 2) begin
                i_key_ack = 1'b0; i_dbl_done = 1'b0; i_add_done = 1'b0;
                i_rst = 1'b1;
                #1;
                check({tag, "_rst_outputs"}, {25'd0, out_vec()}, 32'b0000001);
                @(negedge i_clk);
                i_rst = 1'b0;
                @(negedge i_clk);
                #1;
                check({tag, "_rst_idle_after"}, {25'd0, out_vec()}, 32'b0000001);
                return;
            end
            if (prev_dbl && mode == 1 && !disturbed && !i_dbl_done) begin
                i_start    = 1'b1;
                i_add_done = 1'b1;
                disturbed  = 1'b1;
            end
            #1;
            if ($countones({o_load_p, o_dbl_start, o_add_start, o_key_next}) > 1) n_multi++;
            if (!o_busy) busy_bad++;
            if (o_load_p) n_load++;
            if (o_dbl_start) begin
                n_dbl++;
                dbl_cd   = lat;
                last_dbl = 1'b1;
            end
            if (o_add_start) begin
                n_add++;
                add_cd = lat;
                if (!last_dbl) n_order++;
                last_dbl = 1'b0;
            end
            if (o_key_next) begin
                n_next++;
                ack_due = 1'b1;
                idx--;
            end
            if (o_done) begin
                got_done = 1'b1;
                inf_done = o_inf;
            end
            prev_dbl = o_dbl_start;
        end
        i_start = 1'b0; i_key_ack = 1'b0; i_dbl_done = 1'b0; i_add_done = 1'b0;
        check({tag, "_done_seen"}, got_done, 1'b1);
        check({tag, "_busy_held"}, busy_bad, 0);
        check({tag, "_onehot"}, n_multi, 0);
        @(negedge i_clk);
        #1;
        check({tag, "_post_busy_done"}, {o_busy, o_done}, 2'b00);
        check({tag, "_inf_held"}, o_inf, inf_done);
        if (mode == 1) check({tag, "_disturbed"}, disturbed, 1'b1);
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        #1;
        check("reset_outputs", {25'd0, out_vec()}, 32'b0000001);
        @(negedge i_clk);
        i_rst = 1'b0;

        run_key(32'h0000_0001, 1, 0, "k1");
        check("k1_next", n_next, 31);
        check("k1_load", n_load, 1);
        check("k1_dbl", n_dbl, 0);
        check("k1_add", n_add, 0);
        check("k1_inf", inf_done, 1'b0);

        run_key(32'h8000_0001, 1, 0, "k8");
        check("k8_next", n_next, 31);
        check("k8_load", n_load, 1);
        check("k8_dbl", n_dbl, 31);
        check("k8_add", n_add, 1);
        check("k8_inf", inf_done, 1'b0);

        run_key(32'h0000_0000, 1, 0, "k0");
        check("k0_next", n_next, 31);
        check("k0_ops", n_load + n_dbl + n_add, 0);
        check("k0_inf", inf_done, 1'b1);

        run_key(32'hFFFF_FFFF, 3, 0, "kf");
        check("kf_next", n_next, 31);
        check("kf_load", n_load, 1);
        check("kf_dbl", n_dbl, 31);
        check("kf_add", n_add, 31);
        check("kf_order", n_order, 0);
        check("kf_inf", inf_done, 1'b0);

        // 0xA5: first set bit is bit 7, then 7 doubles and adds for bits 5, 2, 0.
        run_key(32'h0000_00A5, 2, 0, "ka5");
        check("ka5_next", n_next, 31);
        check("ka5_load", n_load, 1);
        check("ka5_dbl", n_dbl, 7);
        check("ka5_add", n_add, 3);

        run_key(32'hFFFF_FFFF, 3, 2, "rst");
        run_key(32'h0000_0001, 1, 0, "rerun");
        check("rerun_next", n_next, 31);
        check("rerun_load", n_load, 1);
        check("rerun_dbl_add", n_dbl + n_add, 0);
        check("rerun_inf", inf_done, 1'b0);

        run_key(32'h8000_0001, 3, 1, "dist");
        check("dist_next", n_next, 31);
        check("dist_load", n_load, 1);
        check("dist_dbl", n_dbl, 31);
        check("dist_add", n_add, 1);
        check("dist_inf", inf_done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
